// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity modes and defaults shared by the UART TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period down-counter; tick marks the last cycle of a bit period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] TOP = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = load ? TOP : !en ? cnt_q : tick ? TOP : cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serializes handshaked bytes onto tx as start, LSB-first data, optional parity, stop bits.
module uart_tx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       tx
);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx: illegal parameter combination");
    end

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 hs, tick;

    assign hs       = tx_valid && ready_q;
    assign tx       = tx_q;
    assign tx_ready = ready_q;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .reset (reset),
        .load  (hs),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:             if (hs) state_d = START;
            START:            if (tick) state_d = DATA;
            DATA:             if (tick && bit_idx_q == LAST_DATA)
                                  state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            uart_pkg::PARITY: if (tick) state_d = STOP;
            STOP:             if (tick && bit_idx_q == LAST_STOP) state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so tx and tx_ready come straight from flops.
    always_comb begin
        shift_d   = hs ? tx_data[DATA_BITS-1:0] : (state_q == DATA && tick) ? shift_q >> 1 : shift_q;
        par_d     = hs ? (^tx_data[DATA_BITS-1:0]) ^ (PARITY == PAR_ODD) : par_q;
        bit_idx_d = (tick && state_q != IDLE) ? ((state_d == state_q) ? bit_idx_q + 3'd1 : 3'd0) : bit_idx_q;
        tx_d      = (state_d == START)            ? 1'b0 :
                    (state_d == DATA)             ? shift_d[0] :
                    (state_d == uart_pkg::PARITY) ? par_q : 1'b1;
        ready_d   = (state_d == IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four uart_tx configurations checked cycle by cycle against a frame-level reference model.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid [4];
    logic [7:0] data [4];
    logic       tx_w [4];
    logic       rdy_w [4];

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8E2
    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (8),
            .PARITY       (g == 0 ? 0 : (g == 2 ? 1 : 2)),
            .STOP_BITS    (g == 3 ? 2 : 1)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .tx_valid (valid[g]),
            .tx_ready (rdy_w[g]),
            .tx_data  (data[g]),
            .tx       (tx_w[g])
        );
    end

    int          par_m [4] = '{0, 2, 1, 2};
    int          stp_m [4] = '{1, 1, 1, 2};
    int          rem [4]   = '{default: 0};
    int          flen [4]  = '{default: 0};
    logic [11:0] fr [4];
    int          accepted [4] = '{default: 0};
    int          frames [4]   = '{default: 0};
    logic        rdy_prev [4];
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       exp_par;
        int         exp_len;
    } vec_t;
    vec_t vt [9];

    function automatic void load_frame(int i, logic [7:0] d);
        int n;
        fr[i] = '1;
        fr[i][0] = 1'b0;
        for (int k = 0; k < 8; k++) fr[i][1+k] = d[k];
        n = 9;
        if (par_m[i] != 0) begin
            fr[i][9] = (par_m[i] == 2) ? ^d : ~^d;
            n++;
        end
        flen[i] = (n + stp_m[i]) * CPB;
        rem[i]  = flen[i];
    endfunction

    function automatic logic exp_tx(int i);
        return (rem[i] == 0) ? 1'b1 : fr[i][(flen[i] - rem[i]) / CPB];
    endfunction

    task automatic check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (reset) rem[i] = 0;
            else if (rem[i] > 0) rem[i]--;
            else if (valid[i]) begin
                load_frame(i, data[i]);
                accepted[i]++;
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tx%0d", i), tx_w[i], exp_tx(i));
            check($sformatf("ready%0d", i), rdy_w[i], rem[i] == 0);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rdy_prev[i] === 1'b1 && rdy_w[i] === 1'b0) frames[i]++;
            rdy_prev[i] = rdy_w[i];
        end
    end

    initial begin
        int i, n, gap;
        logic parb;
        vt = '{'{0, 8'hA5, 1'b0, 40}, '{1, 8'hA5, 1'b0, 44}, '{2, 8'hA5, 1'b1, 44},
               '{1, 8'h07, 1'b1, 44}, '{3, 8'h55, 1'b0, 48}, '{3, 8'h0F, 1'b0, 48},
               '{2, 8'h00, 1'b1, 44}, '{0, 8'hFF, 1'b0, 40}, '{2, 8'h80, 1'b0, 44}};
        for (int k = 0; k < 4; k++) begin
            valid[k] = 1'b0;
            data[k]  = 8'h00;
        end
        repeat (3) step();
        reset = 1'b0;
        repeat (100) step();

        for (int v = 0; v < 9; v++) begin
            i = vt[v].inst;
            data[i]  = vt[v].d;
            valid[i] = 1'b1;
            step();
            valid[i] = 1'b0;
            data[i]  = 8'($urandom);
            n = 0;
            parb = 1'bx;
            while (rdy_w[i] === 1'b0 && n < 200) begin
                if (n == 9 * CPB + CPB / 2) parb = tx_w[i];
                n++;
                step();
            end
            check_int($sformatf("frame_len_v%0d", v), n, vt[v].exp_len);
            if (par_m[i] != 0) check($sformatf("parity_v%0d", v), parb, vt[v].exp_par);
        end

        // Back-to-back 8E2 with valid held high and data churning mid-frame.
        data[3]  = 8'h55;
        valid[3] = 1'b1;
        step();
        data[3] = 8'hAA;
        repeat (20) step();
        data[3] = 8'h0F;
        gap = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (rdy_w[3] === 1'b1) gap++;
            if (k == 30) data[3] = 8'h33;
        end
        valid[3] = 1'b0;
        check_int("b2b_idle_gap", gap, 1);
        repeat (60) step();

        // Reset during data bit 3 of 0x00 on the 8N1 instance.
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        repeat (17) step();
        reset = 1'b1;
        step();
        check("reset_mid_frame_tx", tx_w[0], 1'b1);
        reset = 1'b0;
        repeat (10) step();
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        repeat (45) step();

        // Randomized stall traffic on all instances.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                valid[k] = ($urandom_range(0, 3) != 0);
                data[k]  = 8'($urandom);
            end
            step();
        end
        for (int k = 0; k < 4; k++) valid[k] = 1'b0;
        repeat (60) step();
        for (int k = 0; k < 4; k++) check_int($sformatf("frames_vs_accepted%0d", k), frames[k], accepted[k]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
